// File: rtl/lisnoc_router_input_demux_if.sv
// Link-side and core-side signal bundle of the router input demux.
// The demux attaches through the slave modport; the link/core side uses master.
interface lisnoc_router_input_demux_if #(
  parameter int flit_width = 34,
  parameter int vchannels  = 1
);
  logic [vchannels-1:0]            link_valid_i;
  logic [flit_width-1:0]           link_flit_i;
  logic [vchannels-1:0]            link_ready_o;
  logic [vchannels-1:0]            fifo_valid_o;
  logic [vchannels*flit_width-1:0] fifo_flit_o;
  logic [vchannels-1:0]            fifo_ready_i;

  modport slave (
    input  link_valid_i, link_flit_i, fifo_ready_i,
    output link_ready_o, fifo_valid_o, fifo_flit_o
  );

  modport master (
    output link_valid_i, link_flit_i, fifo_ready_i,
    input  link_ready_o, fifo_valid_o, fifo_flit_o
  );
endinterface

// File: rtl/lisnoc_router_input_demux.sv
// Router input port: steers link flits into one FIFO per virtual channel.
// Optional one-hot check of link_valid_i: LISNOC_INPUT_DEMUX_ONEHOT_CHECK_EN.
module lisnoc_router_input_demux #(
  parameter int flit_data_width = 32,
  parameter int flit_type_width = 2,
  parameter int vchannels       = 1,
  parameter int fifo_depth      = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  lisnoc_router_input_demux_if.slave     i_bus,
  output logic                           err_o
);
  localparam int flit_width = flit_data_width + flit_type_width;
  localparam int ptr_w      = $clog2(fifo_depth);
  localparam int cnt_w      = $clog2(fifo_depth) + 1;

  logic [vchannels-1:0]            w_ready;
  logic [vchannels-1:0]            w_valid;
  logic [vchannels*flit_width-1:0] w_flit;

  for (genvar v = 0; v < vchannels; v++) begin : g_vc
    logic [flit_width-1:0] r_mem [fifo_depth];
    logic [ptr_w-1:0]      r_wr_ptr;
    logic [ptr_w-1:0]      r_rd_ptr;
    logic [cnt_w-1:0]      r_count;
    logic                  w_push;
    logic                  w_pop;

    // Ready comes from registered count only; upstream arbiter loops it back combinationally.
    assign w_ready[v] = (r_count != cnt_w'(fifo_depth)) && !rst;
    assign w_valid[v] = (r_count != '0) && !rst;
    assign w_push     = i_bus.link_valid_i[v] && w_ready[v];
    assign w_pop      = w_valid[v] && i_bus.fifo_ready_i[v];

    always_ff @(posedge clk) begin
      if (rst) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + ptr_w'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + ptr_w'(1);
        if (w_push && !w_pop)      r_count <= r_count + cnt_w'(1);
        else if (!w_push && w_pop) r_count <= r_count - cnt_w'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_bus.link_flit_i;
    end

    assign w_flit[v*flit_width +: flit_width] = r_mem[r_rd_ptr];
  end

  assign i_bus.link_ready_o = w_ready;
  assign i_bus.fifo_valid_o = w_valid;
  assign i_bus.fifo_flit_o  = w_flit;

`ifdef LISNOC_INPUT_DEMUX_ONEHOT_CHECK_EN
  logic r_err;
  logic w_multi;

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign w_multi = (i_bus.link_valid_i & (i_bus.link_valid_i - vchannels'(1))) != '0;

  always_ff @(posedge clk) begin
    if (rst)          r_err <= 1'b0;
    else if (w_multi) r_err <= 1'b1;
  end

  assign err_o = r_err && !rst;
`else
  assign err_o = 1'b0;
`endif
endmodule

// File: tb/tb_lisnoc_router_input_demux.sv
// Self-checking bench: directed scenarios plus random traffic against per-VC queue model.
module tb_lisnoc_router_input_demux;
  localparam int DW    = 32;
  localparam int TW    = 2;
  localparam int FW    = DW + TW;
  localparam int VC    = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  logic err_o;

  lisnoc_router_input_demux_if #(.flit_width(FW), .vchannels(VC)) bus ();

  lisnoc_router_input_demux #(
    .flit_data_width(DW),
    .flit_type_width(TW),
    .vchannels(VC),
    .fifo_depth(DEPTH)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .i_bus (bus.slave),
    .err_o (err_o)
  );

  always #5 clk = ~clk;

  logic [FW-1:0] mq [VC][$];
  logic          err_m;
  int            n_checks;
  int            n_fail;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock: check outputs against the queue model, then advance the model.
  task automatic step();
    logic [VC-1:0] push, pop;
    @(negedge clk);
    for (int v = 0; v < VC; v++) begin
      check_eq($sformatf("ready[%0d]", v), 64'(bus.link_ready_o[v]),
               64'((!rst) && (mq[v].size() != DEPTH)));
      check_eq($sformatf("valid[%0d]", v), 64'(bus.fifo_valid_o[v]),
               64'((!rst) && (mq[v].size() != 0)));
      if (!rst && mq[v].size() != 0)
        check_eq($sformatf("flit[%0d]", v), 64'(bus.fifo_flit_o[v*FW +: FW]), 64'(mq[v][0]));
      push[v] = !rst && bus.link_valid_i[v] && (mq[v].size() < DEPTH);
      pop[v]  = !rst && bus.fifo_ready_i[v] && (mq[v].size() > 0);
    end
    check_eq("err", 64'(err_o), 64'(err_m && !rst));
    @(posedge clk);
    if (rst) begin
      for (int v = 0; v < VC; v++) mq[v].delete();
      err_m = 1'b0;
    end else begin
      for (int v = 0; v < VC; v++) begin
        if (pop[v])  void'(mq[v].pop_front());
        if (push[v]) mq[v].push_back(bus.link_flit_i);
      end
`ifdef LISNOC_INPUT_DEMUX_ONEHOT_CHECK_EN
      if ($countones(bus.link_valid_i) > 1) err_m = 1'b1;
`endif
    end
    #1;
  endtask

  task automatic drive(input logic [VC-1:0] valid, input logic [FW-1:0] flit,
                       input logic [VC-1:0] rdy);
    bus.link_valid_i = valid;
    bus.link_flit_i  = flit;
    bus.fifo_ready_i = rdy;
    step();
  endtask

  initial begin
    logic [VC-1:0] vld;
    int            r;
    n_checks = 0;
    n_fail   = 0;
    err_m    = 1'b0;
    rst      = 1'b1;
    bus.link_valid_i = '0;
    bus.link_flit_i  = '0;
    bus.fifo_ready_i = '0;

    // Reset held with valid asserted: nothing may be stored.
    for (int i = 0; i < 3; i++) drive(2'b01, FW'(32'hDEAD), 2'b00);
    rst = 1'b0;
    drive(2'b00, '0, 2'b00);
    check_eq("reset_empty0", 64'(bus.fifo_valid_o), 64'(0));

    // Fill VC0 with 1..5 (5th rejected), then drain.
    for (int i = 1; i <= 5; i++) drive(2'b01, FW'(i), 2'b00);
    check_eq("full_ready", 64'(bus.link_ready_o), 64'(2'b10));
    for (int i = 1; i <= 4; i++) begin
      check_eq("drain_order", 64'(bus.fifo_flit_o[FW-1:0]), 64'(i));
      drive(2'b00, '0, 2'b01);
    end
    drive(2'b00, '0, 2'b00);

    // VC1 at count 2, push+pop every cycle across wrap.
    drive(2'b10, FW'(32'h100), 2'b00);
    drive(2'b10, FW'(32'h101), 2'b00);
    for (int i = 2; i < 12; i++) drive(2'b10, FW'(32'h100 + i), 2'b10);
    check_eq("steady_count", 64'(mq[1].size()), 64'(2));
    for (int i = 0; i < 3; i++) drive(2'b00, '0, 2'b10);

    // VC0 full and stalled while VC1 streams.
    for (int i = 0; i < 4; i++) drive(2'b01, FW'(32'hB0 + i), 2'b00);
    for (int i = 0; i < 8; i++) drive(2'b10, FW'(32'hA0 + i), 2'b10);
    for (int i = 0; i < 2; i++) drive(2'b00, '0, 2'b10);
    check_eq("iso_vc0_head", 64'(bus.fifo_flit_o[FW-1:0]), 64'(32'hB0));

    // Mid-operation reset discards buffered flits.
    for (int i = 0; i < 4; i++) drive(2'b00, '0, 2'b01);
    for (int i = 0; i < 3; i++) drive(2'b01, FW'(32'hC0 + i), 2'b00);
    rst = 1'b1;
    drive(2'b01, FW'(32'hEE), 2'b01);
    rst = 1'b0;
    drive(2'b01, FW'(32'h55), 2'b00);
    check_eq("post_rst_head", 64'(bus.fifo_flit_o[FW-1:0]), 64'(32'h55));
    drive(2'b00, '0, 2'b01);

    // Two valid bits in one cycle; error (if built in) is sticky until reset.
    drive(2'b11, FW'(32'h77), 2'b11);
    for (int i = 0; i < 4; i++) drive(2'b00, '0, 2'b11);
    rst = 1'b1;
    drive(2'b00, '0, 2'b00);
    rst = 1'b0;

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      r = $urandom_range(0, 29);
      if (r == 0)      vld = 2'b11;
      else if (r < 5)  vld = 2'b00;
      else             vld = VC'(1) << $urandom_range(0, VC-1);
      drive(vld, {TW'($urandom_range(0, 3)), DW'($urandom)}, VC'($urandom_range(0, 3)));
    end
    rst = 1'b0;
    drive(2'b00, '0, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
